// File: rtl/axi4_arb_pkg.sv
// axi4_arb_pkg: shared FSM states and AXI constants for the request arbiter
package axi4_arb_pkg;
  typedef enum logic [2:0] {IDLE, WR, B_WAIT, RD, R_WAIT, RESP} state_t;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] INCR   = 2'b01;
endpackage

// File: rtl/axi4_rr_grant2.sv
// axi4_rr_grant2: two-way round-robin grant, ptr names the requester with priority
module axi4_rr_grant2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);
  assign gnt[0] = req[0] & (~ptr | ~req[1]);
  assign gnt[1] = req[1] & (ptr | ~req[0]);
endmodule

// File: rtl/axi4_master_req_arbiter.sv
// axi4_master_req_arbiter: two requesters share one AXI4 master, one single-beat transaction at a time
module axi4_master_req_arbiter
  import axi4_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic [1:0]                       req_valid,
  output logic [1:0]                       req_ready,
  input  logic [1:0]                       req_write,
  input  logic [1:0][ADDR_WIDTH-1:0]       req_addr,
  input  logic [1:0][DATA_WIDTH-1:0]       req_wdata,
  input  logic [1:0][DATA_WIDTH/8-1:0]     req_wstrb,
  output logic [1:0]                       resp_valid,
  output logic [DATA_WIDTH-1:0]            resp_rdata,
  output logic [1:0]                       resp_code,
  output logic [ID_WIDTH-1:0]              awid,
  output logic [ADDR_WIDTH-1:0]            awaddr,
  output logic [7:0]                       awlen,
  output logic [2:0]                       awsize,
  output logic [1:0]                       awburst,
  output logic                             awvalid,
  input  logic                             awready,
  output logic [DATA_WIDTH-1:0]            wdata,
  output logic [DATA_WIDTH/8-1:0]          wstrb,
  output logic                             wlast,
  output logic                             wvalid,
  input  logic                             wready,
  input  logic [ID_WIDTH-1:0]              bid,
  input  logic [1:0]                       bresp,
  input  logic                             bvalid,
  output logic                             bready,
  output logic [ID_WIDTH-1:0]              arid,
  output logic [ADDR_WIDTH-1:0]            araddr,
  output logic [7:0]                       arlen,
  output logic [2:0]                       arsize,
  output logic [1:0]                       arburst,
  output logic                             arvalid,
  input  logic                             arready,
  input  logic [ID_WIDTH-1:0]              rid,
  input  logic [DATA_WIDTH-1:0]            rdata,
  input  logic [1:0]                       rresp,
  input  logic                             rlast,
  input  logic                             rvalid,
  output logic                             rready,
  output logic                             timeout_err
);
  localparam logic [2:0] SIZE = 3'($clog2(DATA_WIDTH / 8));
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  logic [1:0] gnt;
  logic ptr, g_q, aw_done, w_done, err_q, tout, counting, aw_ok, w_ok;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic [1:0] code_q;
  logic [CW-1:0] cnt;
  logic [ID_WIDTH-1:0] id;
  axi4_rr_grant2 u_grant (.req(req_valid), .ptr(ptr), .gnt(gnt));
  assign id          = ID_WIDTH'(g_q);
  assign awvalid     = (state == WR) & ~aw_done;
  assign wvalid      = (state == WR) & ~w_done;
  assign bready      = state == B_WAIT;
  assign arvalid     = state == RD;
  assign rready      = state == R_WAIT;
  assign req_ready   = (state == IDLE && !areset) ? gnt : 2'b00;
  assign resp_valid  = (state == RESP) ? {g_q, ~g_q} : 2'b00;
  assign resp_rdata  = rdata_q;
  assign resp_code   = code_q;
  assign timeout_err = tout;
  assign awid        = id;
  assign arid        = id;
  assign awaddr      = addr_q;
  assign araddr      = addr_q;
  assign awlen       = 8'd0;
  assign arlen       = 8'd0;
  assign awsize      = awvalid ? SIZE : 3'd0;
  assign arsize      = arvalid ? SIZE : 3'd0;
  assign awburst     = awvalid ? INCR : 2'b00;
  assign arburst     = arvalid ? INCR : 2'b00;
  assign wdata       = wdata_q;
  assign wstrb       = wstrb_q;
  assign wlast       = wvalid;
  assign aw_ok       = aw_done | (awvalid & awready);
  assign w_ok        = w_done | (wvalid & wready);
  assign counting    = state inside {WR, B_WAIT, RD, R_WAIT};
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (|req_valid) state_n = req_write[gnt[1]] ? WR : RD;
      WR:      if (aw_ok && w_ok) state_n = B_WAIT;
      B_WAIT:  if (bvalid) state_n = RESP;
      RD:      if (arready) state_n = R_WAIT;
      R_WAIT:  if (rvalid && rlast) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      g_q     <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= OKAY;
      rdata_q <= '0;
      cnt     <= '0;
      tout    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= (state_n != state) ? '0 : (counting && cnt != CW'(TIMEOUT)) ? cnt + 1'b1 : cnt;
      if (counting && state_n == state && cnt == CW'(TIMEOUT - 1)) tout <= 1'b1;
      if (state == IDLE && |req_valid) begin
        g_q     <= gnt[1];
        addr_q  <= req_addr[gnt[1]];
        wdata_q <= req_wdata[gnt[1]];
        wstrb_q <= req_wstrb[gnt[1]];
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        err_q   <= 1'b0;
      end
      if (awvalid && awready) aw_done <= 1'b1;
      if (wvalid && wready) w_done <= 1'b1;
      if (bready && bvalid) begin
        code_q  <= (bid != id) ? SLVERR : bresp;
        rdata_q <= '0;
      end
      // a non-last beat poisons the whole transfer, since only single beats were requested
      if (rready && rvalid) begin
        rdata_q <= rdata;
        code_q  <= (err_q || !rlast || rid != id) ? SLVERR : rresp;
        if (!rlast) err_q <= 1'b1;
      end
      if (state == RESP) ptr <= ~g_q;
    end
  end
endmodule

// File: doc/axi4_master_req_arbiter.md
AXI4_MASTER_REQ_ARBITER -- requirements
Module: axi4_master_req_arbiter

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 SHALL take these parameters: ADDR_WIDTH, default 32, address width; DATA_WIDTH, default 32, data width; ID_WIDTH, default 4, AXI ID width; TIMEOUT, default 1024, watchdog limit in cycles.
REQ-003 SHALL have these ports, one per line as name, direction, width, meaning:
- aclk  in  1  clock.
- areset  in  1  synchronous active-high reset.
- req_valid  in  [1:0]  per-requester command valid.
- req_ready  out  [1:0]  command accepted.
- req_write  in  [1:0]  1 = write, 0 = read.
- req_addr  in  [1:0][ADDR_WIDTH]  command address.
- req_wdata  in  [1:0][DATA_WIDTH]  write data.
- req_wstrb  in  [1:0][DATA_WIDTH/8]  write strobes.
- resp_valid  out  [1:0]  one-cycle completion pulse.
- resp_rdata  out  DATA_WIDTH  read data, valid with resp_valid.
- resp_code  out  2  AXI response code.
- awid/awaddr/awlen/awsize/awburst/awvalid  out  ID/ADDR/8/3/2/1  AW channel.
- awready  in  1  AW channel ready.
- wdata/wstrb/wlast/wvalid  out  DATA/DATA/8/1/1  W channel.
- wready  in  1  W channel ready.
- bid/bresp/bvalid  in  ID/2/1  B channel.
- bready  out  1  B channel ready.
- arid/araddr/arlen/arsize/arburst/arvalid  out  ID/ADDR/8/3/2/1  AR channel.
- arready  in  1  AR channel ready.
- rid/rdata/rresp/rlast/rvalid  in  ID/DATA/2/1/1  R channel.
- rready  out  1  R channel ready.
- timeout_err  out  1  sticky watchdog flag.
REQ-004 SHALL NOT carry lock, cache, prot, qos or region ports; the integrating wrapper ties these to 0.

Function
REQ-005 SHALL keep exactly one AXI transaction outstanding at any time.
REQ-006 SHALL issue only single-beat bursts: len=0, burst=INCR (2'b01), size=log2(DATA_WIDTH/8), wlast=1.
REQ-007 SHALL drive awid and arid with the granted requester index, zero-extended to ID_WIDTH.
REQ-008 SHALL implement the FSM states IDLE, WR, B_WAIT, RD, R_WAIT, RESP.
REQ-009 SHALL arbitrate only in IDLE:
- choose round-robin among asserted req_valid bits.
- pulse req_ready[g] for one cycle.
- register write, addr, wdata and wstrb.
- go to WR (write) or RD (read).
REQ-010 SHALL keep req_ready at 0 in every state other than IDLE.
REQ-011 SHALL, in WR, assert awvalid and wvalid together and hold each until its own handshake, tracking aw_done and w_done independently.
REQ-012 SHALL leave WR for B_WAIT in the cycle after both aw_done and w_done are set, including when both handshakes occur in the same cycle.
REQ-013 SHALL hold addr, data and control outputs stable while the matching valid is high.
REQ-014 SHALL assert bready=1 in B_WAIT and, on bvalid, capture bresp and go to RESP.
REQ-015 SHALL assert arvalid in RD until arready, then go to R_WAIT.
REQ-016 SHALL assert rready=1 in R_WAIT and, on rvalid, capture rdata and rresp.
REQ-017 SHALL go from R_WAIT to RESP only on a beat with rlast=1; a beat with rlast=0 is consumed and forces the final code to SLVERR.
REQ-018 SHALL force resp_code to SLVERR (2'b10) when bid or rid differs from the issued ID.
REQ-019 SHALL, in RESP, pulse resp_valid[g] for one cycle (no backpressure), move the round-robin pointer to the other requester, and return to IDLE.
REQ-020 SHALL hold resp_rdata at the last captured read data and drive it to 0 after a write.
REQ-021 SHALL meet this latency with a zero-wait slave: accept at cycle 0, valid at cycle 1, resp_valid at cycle 3 for a write and at cycle 3 for a read.
REQ-022 SHALL run a watchdog counter:
- clear it on every state change.
- increment it in WR, B_WAIT, RD and R_WAIT.
- on reaching TIMEOUT, set timeout_err (sticky) and saturate the counter.
- keep the AXI valids held; never drop one.
REQ-023 SHALL, with both requesters valid and the pointer at 0, grant requester 0 first and requester 1 next.

Reset
REQ-024 SHALL, on areset, go to IDLE and drive 0 on every output: valids, readys, resp_valid, resp_rdata, resp_code, timeout_err, and all address and data outputs.
REQ-025 SHALL, on areset, clear the watchdog counter and the round-robin pointer (pointer=0).
REQ-026 SHALL abandon any in-flight transaction when areset is asserted mid-operation, with no response pulse.

Structure
REQ-027 SHALL put the state enum, the AXI response constants (OKAY, SLVERR) and the INCR burst constant in the shared package axi4_arb_pkg.
REQ-028 SHALL put round-robin grant selection in one sub-module, axi4_rr_grant2, with inputs req[1:0] and ptr and output one-hot gnt.

Verification
REQ-029 SHALL cover these directed scenarios:
- Requester 0 writes addr=0x1000, data=0xDEADBEEF, strb=0xF to a zero-wait slave -> AW and W handshake at cycle 1; resp_valid[0] at cycle 3 with code OKAY.
- Requester 1 reads 0x2000; slave returns rdata=0xCAFEF00D after arready is held low for 4 cycles -> resp_rdata=0xCAFEF00D, resp_valid[1]=1, arvalid held stable through the stall.
- Both requesters valid for 4 consecutive commands -> grants alternate 0,1,0,1.
- wready asserted 3 cycles after awready -> bready asserted only after both done; single AW and single W handshake.
- bid=5 returned for issued ID 0 -> resp_code=2'b10. With TIMEOUT=16 and awready stuck low -> timeout_err=1 at cycle 17 and awvalid still 1.
- areset pulsed during B_WAIT -> all outputs 0 next cycle, state IDLE, no resp_valid.
